// File: rtl/mkio_pkg.sv
`default_nettype none
// ============================================================================
// mkio_pkg : shared types and constants for the MIL-STD-1553 bus controller
// Rev 1.0  : initial release
// ============================================================================
package mkio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_CMD    = 3'd1,
        ST_SEND_DATA   = 3'd2,
        ST_WAIT_STATUS = 3'd3,
        ST_RECV_DATA   = 3'd4,
        ST_FINISH      = 3'd5
    } state_e;

    localparam logic [2:0] C_ERR_NONE    = 3'd0;
    localparam logic [2:0] C_ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] C_ERR_PARITY  = 3'd2;
    localparam logic [2:0] C_ERR_SYNC    = 3'd3;
    localparam logic [2:0] C_ERR_ADDR    = 3'd4;

    localparam int C_CMD_RT_LSB = 11;
    localparam int C_CMD_TR_BIT = 10;
    localparam int C_CMD_SA_LSB = 5;
    localparam int C_CMD_WC_LSB = 0;

    localparam int C_DEF_TIMEOUT_CYCLES = 448;

    function automatic logic [15:0] build_cmd(input logic [4:0] rt, input logic tr,
                                              input logic [4:0] sa, input logic [4:0] wc);
        logic [15:0] w;
        w                      = '0;
        w[C_CMD_RT_LSB +: 5]   = rt;
        w[C_CMD_TR_BIT]        = tr;
        w[C_CMD_SA_LSB +: 5]   = sa;
        w[C_CMD_WC_LSB +: 5]   = wc;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mkio_bc_timer.sv
`default_nettype none
// ============================================================================
// mkio_bc_timer : saturating response-timeout counter, expires after
//                 TIMEOUT_CYCLES uncleared cycles
// Rev 1.0       : initial release
// ============================================================================
module mkio_bc_timer
    import mkio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int              C_CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

    logic [C_CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + C_ONE;
        end
    end

    assign expired = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mkio_bc_control.sv
`default_nettype none
// ============================================================================
// mkio_bc_control : 1553 bus-controller transaction sequencer (BC->RT, RT->BC)
//                   Option macro: MKIO_BC_RETRY_EN (retry once on any error)
// Rev 1.0         : initial release
// ============================================================================
module mkio_bc_control
    import mkio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  rt_addr,
    input  logic        tr,
    input  logic [4:0]  subaddr,
    input  logic [4:0]  word_count,
    output logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [4:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_we,
    output logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    input  logic        tx_busy,
    input  logic        rx_done,
    input  logic [15:0] rx_data,
    input  logic        rx_cd,
    input  logic        p_error,
    output logic        busy,
    output logic        done,
    output logic [15:0] status_word,
    output logic [2:0]  err
);

    localparam logic [1:0] C_PH_ISSUE   = 2'd0;
    localparam logic [1:0] C_PH_WAIT_HI = 2'd1;
    localparam logic [1:0] C_PH_WAIT_LO = 2'd2;

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [4:0]  rt_q, rt_d, sa_q, sa_d, wc_q, wc_d;
    logic        tr_q, tr_d;
    logic [5:0]  idx_q, idx_d;
    logic        tx_ready_q, tx_ready_d, tx_cd_q, tx_cd_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        rd_we_q, rd_we_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [2:0]  err_q, err_d;
    logic [15:0] status_q, status_d;
`ifdef MKIO_BC_RETRY_EN
    logic        retry_q, retry_d;
`endif

    logic        w_sent, w_last, w_fail, w_tmr_clr, w_tmr_exp;
    logic [2:0]  w_fail_code;
    logic [5:0]  w_n;

    // Word count 0 encodes 32; 6-bit index keeps the final-word compare unambiguous
    assign w_n       = (wc_q == 5'd0) ? 6'd32 : {1'b0, wc_q};
    assign w_last    = (idx_q == (w_n - 6'd1));
    assign w_tmr_clr = !((state_q == ST_WAIT_STATUS) || (state_q == ST_RECV_DATA)) || rx_done;

    mkio_bc_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_tmr_clr),
        .expired (w_tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= C_PH_ISSUE;
            rt_q       <= '0;
            tr_q       <= 1'b0;
            sa_q       <= '0;
            wc_q       <= '0;
            idx_q      <= '0;
            tx_ready_q <= 1'b0;
            tx_data_q  <= '0;
            tx_cd_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            err_q      <= C_ERR_NONE;
            status_q   <= '0;
`ifdef MKIO_BC_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rt_q       <= rt_d;
            tr_q       <= tr_d;
            sa_q       <= sa_d;
            wc_q       <= wc_d;
            idx_q      <= idx_d;
            tx_ready_q <= tx_ready_d;
            tx_data_q  <= tx_data_d;
            tx_cd_q    <= tx_cd_d;
            rd_we_q    <= rd_we_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            err_q      <= err_d;
            status_q   <= status_d;
`ifdef MKIO_BC_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rt_d        = rt_q;
        tr_d        = tr_q;
        sa_d        = sa_q;
        wc_d        = wc_q;
        idx_d       = idx_q;
        tx_ready_d  = 1'b0;
        tx_data_d   = tx_data_q;
        tx_cd_d     = tx_cd_q;
        rd_we_d     = 1'b0;
        rd_data_d   = rd_data_q;
        rd_addr_d   = rd_addr_q;
        err_d       = err_q;
        status_d    = status_q;
        w_sent      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = C_ERR_NONE;
`ifdef MKIO_BC_RETRY_EN
        retry_d     = retry_q;
`endif

        // Issue -> see busy rise -> see busy fall, shared by command and data words
        if ((state_q == ST_SEND_CMD) || (state_q == ST_SEND_DATA)) begin
            case (phase_q)
                C_PH_ISSUE: begin
                    if (!tx_busy) begin
                        tx_ready_d = 1'b1;
                        tx_cd_d    = (state_q == ST_SEND_CMD);
                        tx_data_d  = (state_q == ST_SEND_CMD) ? build_cmd(rt_q, tr_q, sa_q, wc_q)
                                                              : wr_data;
                        phase_d    = C_PH_WAIT_HI;
                    end
                end
                C_PH_WAIT_HI: begin
                    if (tx_busy) phase_d = C_PH_WAIT_LO;
                end
                default: begin
                    if (!tx_busy) begin
                        w_sent  = 1'b1;
                        phase_d = C_PH_ISSUE;
                    end
                end
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rt_d    = rt_addr;
                    tr_d    = tr;
                    sa_d    = subaddr;
                    wc_d    = word_count;
                    idx_d   = '0;
                    phase_d = C_PH_ISSUE;
                    err_d   = C_ERR_NONE;
`ifdef MKIO_BC_RETRY_EN
                    retry_d = 1'b0;
`endif
                    state_d = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (w_sent) begin
                    idx_d   = '0;
                    state_d = tr_q ? ST_WAIT_STATUS : ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (w_sent) begin
                    if (w_last) state_d = ST_WAIT_STATUS;
                    else        idx_d   = idx_q + 6'd1;
                end
            end
            ST_WAIT_STATUS: begin
                if (rx_done) begin
                    if (p_error) begin
                        w_fail = 1'b1; w_fail_code = C_ERR_PARITY;
                    end else if (!rx_cd) begin
                        w_fail = 1'b1; w_fail_code = C_ERR_SYNC;
                    end else if (rx_data[15:11] != rt_q) begin
                        w_fail = 1'b1; w_fail_code = C_ERR_ADDR;
                    end else begin
                        status_d = rx_data;
                        idx_d    = '0;
                        if (tr_q) begin
                            state_d = ST_RECV_DATA;
                        end else begin
                            err_d   = C_ERR_NONE;
                            state_d = ST_FINISH;
                        end
                    end
                end else if (w_tmr_exp) begin
                    w_fail = 1'b1; w_fail_code = C_ERR_TIMEOUT;
                end
            end
            ST_RECV_DATA: begin
                if (rx_done) begin
                    if (p_error) begin
                        w_fail = 1'b1; w_fail_code = C_ERR_PARITY;
                    end else if (rx_cd) begin
                        w_fail = 1'b1; w_fail_code = C_ERR_SYNC;
                    end else begin
                        rd_we_d   = 1'b1;
                        rd_data_d = rx_data;
                        rd_addr_d = idx_q[4:0];
                        if (w_last) begin
                            err_d   = C_ERR_NONE;
                            state_d = ST_FINISH;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                        end
                    end
                end else if (w_tmr_exp) begin
                    w_fail = 1'b1; w_fail_code = C_ERR_TIMEOUT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (w_fail) begin
`ifdef MKIO_BC_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                idx_d   = '0;
                phase_d = C_PH_ISSUE;
                state_d = ST_SEND_CMD;
            end else begin
                err_d   = w_fail_code;
                state_d = ST_FINISH;
            end
`else
            err_d   = w_fail_code;
            state_d = ST_FINISH;
`endif
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        done = (state_q == ST_FINISH);
    end

    assign wr_addr     = idx_q[4:0];
    assign rd_addr     = rd_addr_q;
    assign rd_data     = rd_data_q;
    assign rd_we       = rd_we_q;
    assign tx_ready    = tx_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_cd       = tx_cd_q;
    assign status_word = status_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mkio_bc_control.sv
`default_nettype none
// ============================================================================
// tb_mkio_bc_control : transmitter/RT bench for mkio_bc_control
// Rev 1.0            : initial release
// ============================================================================
module tb_mkio_bc_control;

    localparam int TMO = 448;
`ifdef MKIO_BC_RETRY_EN
    localparam int RETRY = 1;
`else
    localparam int RETRY = 0;
`endif

    localparam int S_OK = 0, S_NOREPLY = 1, S_SPAR = 2, S_SSYNC = 3,
                   S_ADDR = 4, S_DPAR = 5, S_DSYNC = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, tr = 1'b0;
    logic [4:0]  rt_addr = '0, subaddr = '0, word_count = '0;
    logic [4:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data, tx_data, status_word;
    logic [15:0] rx_data = '0;
    logic        rd_we, tx_ready, tx_cd, busy, done;
    logic        tx_busy = 1'b0, rx_done = 1'b0, rx_cd = 1'b0, p_error = 1'b0;
    logic [2:0]  err;

    int          n_assert = 0, n_fail = 0;
    int          cyc = 0, last_fall = 0, busy_cnt = 0;
    int          done_cnt = 0, done_cyc = 0;
    logic [2:0]  done_err = '0;
    logic [16:0] tx_log[$];
    logic [20:0] rd_log[$];
    logic [15:0] tx_buf[32];
    logic [15:0] exp_status = '0;

    mkio_bc_control #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .rt_addr(rt_addr), .tr(tr),
        .subaddr(subaddr), .word_count(word_count), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_cd(tx_cd), .tx_busy(tx_busy), .rx_done(rx_done),
        .rx_data(rx_data), .rx_cd(rx_cd), .p_error(p_error), .busy(busy), .done(done),
        .status_word(status_word), .err(err)
    );

    assign wr_data = tx_buf[wr_addr];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter: accepts a word on tx_ready, stays busy 1..4 cycles
    initial forever begin
        logic busy_prev;
        @(negedge clk);
        busy_prev = tx_busy;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy   = 1'b0;
                last_fall = cyc + 1;
            end
        end
        if (tx_ready === 1'b1) begin
            check("tx_ready_while_idle", {31'd0, busy_prev}, 32'd0);
            tx_log.push_back({tx_cd, tx_data});
            tx_busy  = 1'b1;
            busy_cnt = $urandom_range(1, 4);
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        if (rd_we === 1'b1) rd_log.push_back({rd_addr, rd_data});
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [15:0] d, input logic cd, input logic pe);
        @(negedge clk);
        rx_data = d; rx_cd = cd; p_error = pe; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; p_error = 1'b0;
    endtask

    task automatic run_txn(input logic t, input logic [4:0] rt, input logic [4:0] sa,
                           input logic [4:0] wc, input int scen_in, input int errj,
                           input logic [10:0] slo, input bit intrude);
        int          n, att, per, guard, scen;
        logic [2:0]  exp_err;
        logic [15:0] cmd, st, d;
        logic [16:0] exp_tx[$];
        logic [20:0] exp_rd[$];
        bit          stalled;
        scen = scen_in;
        if (!t && scen >= S_DPAR) scen = S_OK;
        n = (wc == 5'd0) ? 32 : int'(wc);
        case (scen)
            S_NOREPLY:     exp_err = 3'd1;
            S_SPAR, S_DPAR: exp_err = 3'd2;
            S_SSYNC, S_DSYNC: exp_err = 3'd3;
            S_ADDR:        exp_err = 3'd4;
            default:       exp_err = 3'd0;
        endcase
        att = (exp_err != 3'd0 && RETRY != 0) ? 2 : 1;
        for (int i = 0; i < 32; i++) tx_buf[i] = 16'($urandom);
        cmd = 16'(rt) * 16'd2048 + 16'(t) * 16'd1024 + 16'(sa) * 16'd32 + 16'(wc);
        per = t ? 1 : 1 + n;
        for (int a = 0; a < att; a++) begin
            exp_tx.push_back({1'b1, cmd});
            if (!t) for (int j = 0; j < n; j++) exp_tx.push_back({1'b0, tx_buf[j]});
        end
        st = {(scen == S_ADDR) ? (rt ^ 5'd1) : rt, slo};
        tx_log.delete(); rd_log.delete(); done_cnt = 0; stalled = 0;

        @(negedge clk);
        rt_addr = rt; tr = t; subaddr = sa; word_count = wc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rt_addr = 5'($urandom); tr = 1'($urandom); subaddr = 5'($urandom); word_count = 5'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (intrude) begin
            rx_data = 16'($urandom); rx_cd = 1'b1; p_error = 1'b0; rx_done = 1'b1; start = 1'b1;
            @(negedge clk);
            rx_done = 1'b0; start = 1'b0;
        end

        for (int a = 0; a < att && !stalled; a++) begin
            guard = 0;
            while (tx_log.size() < per * (a + 1) && guard < TMO + 500) begin
                @(negedge clk); guard++;
            end
            check("tx_words_arrive", {31'd0, tx_log.size() >= per * (a + 1)}, 32'd1);
            if (tx_log.size() < per * (a + 1)) stalled = 1;
            guard = 0;
            while (!(tx_busy == 1'b0 && cyc >= last_fall) && guard < 100) begin
                @(negedge clk); guard++;
            end
            wait_cycles($urandom_range(0, 3));
            if (!stalled && scen != S_NOREPLY) begin
                send_rx(st, scen != S_SSYNC, scen == S_SPAR);
                if (t && (scen == S_OK || scen == S_DPAR || scen == S_DSYNC)) begin
                    for (int j = 0; j < n; j++) begin
                        wait_cycles($urandom_range(0, 3));
                        d = 16'($urandom);
                        if (j == errj && scen == S_DPAR) begin
                            send_rx(d, 1'b0, 1'b1); break;
                        end else if (j == errj && scen == S_DSYNC) begin
                            send_rx(d, 1'b1, 1'b0); break;
                        end else begin
                            exp_rd.push_back({5'(j), d});
                            send_rx(d, 1'b0, 1'b0);
                        end
                    end
                end
            end
        end

        guard = 0;
        while (done_cnt == 0 && guard < TMO + 500) begin
            @(negedge clk); guard++;
        end
        wait_cycles(3);
        if (scen == S_OK || scen == S_DPAR || scen == S_DSYNC) exp_status = st;
        check("done_count", done_cnt, 32'd1);
        check("err_at_done", {29'd0, done_err}, {29'd0, exp_err});
        check("err_held", {29'd0, err}, {29'd0, exp_err});
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("status_word", {16'd0, status_word}, {16'd0, exp_status});
        check("tx_count", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check($sformatf("tx_word[%0d]", i), {15'd0, tx_log[i]}, {15'd0, exp_tx[i]});
        check("rd_count", rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check($sformatf("rd_write[%0d]", i), {11'd0, rd_log[i]}, {11'd0, exp_rd[i]});
        if (scen == S_NOREPLY) check("timeout_latency", done_cyc - last_fall, TMO);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 32; i++) tx_buf[i] = '0;
        wait_cycles(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {29'd0, err}, 32'd0);
        check("rst_status", {16'd0, status_word}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        reset = 1'b0;
        wait_cycles(2);

        // Directed transactions
        run_txn(1'b0, 5'd3, 5'd2, 5'd2,  S_OK,      0, 11'h000, 1'b0);
        run_txn(1'b1, 5'd5, 5'd9, 5'd0,  S_OK,      0, 11'h000, 1'b1);
        run_txn(1'b0, 5'd7, 5'd1, 5'd1,  S_NOREPLY, 0, 11'h000, 1'b0);
        run_txn(1'b1, 5'd5, 5'd4, 5'd3,  S_ADDR,    0, 11'h000, 1'b0);
        run_txn(1'b1, 5'd9, 5'd6, 5'd4,  S_DPAR,    2, 11'h155, 1'b0);
        run_txn(1'b0, 5'd2, 5'd3, 5'd3,  S_SPAR,    0, 11'h012, 1'b0);
        run_txn(1'b1, 5'd30, 5'd7, 5'd2, S_SSYNC,   0, 11'h7FF, 1'b0);
        run_txn(1'b1, 5'd17, 5'd8, 5'd5, S_DSYNC,   0, 11'h3A0, 1'b0);
        run_txn(1'b0, 5'd31, 5'd31, 5'd0, S_OK,     0, 11'h401, 1'b1);

        // rx_done while idle must not disturb anything
        done_cnt = 0; rd_log.delete();
        send_rx({5'd31, 11'h5A5}, 1'b1, 1'b0);
        wait_cycles(2);
        check("idle_rx_busy", {31'd0, busy}, 32'd0);
        check("idle_rx_done", done_cnt, 32'd0);
        check("idle_rx_rdwe", rd_log.size(), 32'd0);
        check("idle_rx_status", {16'd0, status_word}, {16'd0, exp_status});

        // Reset during data phase
        for (int i = 0; i < 32; i++) tx_buf[i] = 16'($urandom);
        tx_log.delete(); done_cnt = 0;
        @(negedge clk);
        rt_addr = 5'd6; tr = 1'b0; subaddr = 5'd2; word_count = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (tx_log.size() < 2 && guard < 200) begin @(negedge clk); guard++; end
        check("reached_send_data", {31'd0, tx_log.size() >= 2}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("mid_rst_rd_we", {31'd0, rd_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {29'd0, err}, 32'd0);
        check("mid_rst_status", {16'd0, status_word}, 32'd0);
        check("mid_rst_tx_data", {16'd0, tx_data}, 32'd0);
        check("mid_rst_tx_cd", {31'd0, tx_cd}, 32'd0);
        check("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("mid_rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        reset = 1'b0;
        exp_status = '0;
        wait_cycles(2);
        check("mid_rst_no_done", done_cnt, 32'd0);
        run_txn(1'b0, 5'd6, 5'd2, 5'd5, S_OK, 0, 11'h0F0, 1'b0);

        // Randomized transactions
        for (int k = 0; k < 8; k++) begin
            int r, sc;
            logic t;
            logic [4:0] wc;
            t  = 1'($urandom);
            wc = 5'($urandom);
            r  = $urandom_range(0, 9);
            sc = (r < 4) ? S_OK : r - 3;
            run_txn(t, 5'($urandom), 5'($urandom), wc, sc,
                    $urandom_range(0, ((wc == 5'd0) ? 32 : int'(wc)) - 1),
                    11'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
